horizontal_tf_packer: RTL and testbench

//  Write side of the horizontal twiddle-factor ROM banks. Accepts a stream of P_WIDTH twiddles,
//  15 per table row (tf1..tf15). Packs them into the 8-bank layout the horizontal twiddle unpacker reads:

---
 rtl/horizontal_tf_packer_pkg.sv | 22 ++
 rtl/horizontal_tf_packer.sv | 131 +++++++++++++
 tb/tb_horizontal_tf_packer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/horizontal_tf_packer_pkg.sv
// Shared constants and types for the horizontal twiddle-factor ROM banks.
// The packer (write side) and the unpacker (read side) use the same values:
//   TF_P_WIDTH  / SEG1 : width of one twiddle word
//   TF_SD_WIDTH / SEG2 : width of one packed bank word (two twiddles)
//   NUM_BANKS          : bank0 holds tf1, banks 1..7 hold {tf(2k), tf(2k+1)}
//   TF_PER_ROW         : twiddles per table row (tf1..tf15)
package horizontal_tf_packer_pkg;

    localparam int SEG1        = 64;
    localparam int SEG2        = 128;
    localparam int TF_P_WIDTH  = SEG1;
    localparam int TF_SD_WIDTH = SEG2;
    localparam int NUM_BANKS   = 8;
    localparam int TF_PER_ROW  = 15;
    localparam int SLOT_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } tf_state_t;

endpackage

// File: rtl/horizontal_tf_packer.sv
// horizontal_tf_packer
// Packs a stream of twiddle words (tf1..tf15 per row, rows ascending) into
// the 8-bank horizontal ROM layout and issues one-hot bank writes.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   pulse to begin a run of DEPTH rows (honoured in IDLE only)
//   tf_in        in   twiddle beat
//   tf_in_valid  in   tf_in holds a valid beat
//   tf_in_ready  out  high while loading; beat accepted on valid && ready
//   wr_addr      out  row address shared by all banks
//   wr_data      out  bank write data (bank0 zero-extended)
//   wr_en        out  one-hot bank write strobe
//   busy         out  run in progress
//   done         out  pulse coincident with the final write of the run
module horizontal_tf_packer
    import horizontal_tf_packer_pkg::*;
#(
    parameter int P_WIDTH    = TF_P_WIDTH,
    parameter int SD_WIDTH   = TF_SD_WIDTH,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [P_WIDTH-1:0]    tf_in,
    input  logic                  tf_in_valid,
    output logic                  tf_in_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [SD_WIDTH-1:0]   wr_data,
    output logic [NUM_BANKS-1:0]  wr_en,
    output logic                  busy,
    output logic                  done
);

    generate
        if (SD_WIDTH != 2 * P_WIDTH) begin : g_bad_sd_width
            $error("horizontal_tf_packer: SD_WIDTH must equal 2*P_WIDTH");
        end
        if ((DEPTH < 1) || (DEPTH > (1 << ADDR_WIDTH))) begin : g_bad_depth
            $error("horizontal_tf_packer: DEPTH must be 1..2**ADDR_WIDTH");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(TF_PER_ROW - 1);

    tf_state_t              r_state;
    tf_state_t              w_state_nxt;
    logic [SLOT_W-1:0]      r_slot;
    logic [ADDR_WIDTH-1:0]  r_row;
    logic [P_WIDTH-1:0]     r_hold;
    logic [NUM_BANKS-1:0]   r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [SD_WIDTH-1:0]    r_wr_data;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_slot_last;
    logic                   w_row_last;
    logic                   w_run_last;
    logic [NUM_BANKS-1:0]   w_bank_sel;
    logic [SD_WIDTH-1:0]    w_pack;

    assign tf_in_ready = (r_state == LOAD);
    assign busy        = (r_state == LOAD);
    assign w_accept    = tf_in_valid && (r_state == LOAD);
    assign w_slot_last = (r_slot == LAST_SLOT);
    assign w_row_last  = (r_row == LAST_ROW);
    assign w_run_last  = w_accept && w_slot_last && w_row_last;

    // Slot 0 is bank0; each even slot 2k closes the pair for bank k.
    assign w_bank_sel  = NUM_BANKS'(1) << r_slot[SLOT_W-1:1];
    // bank0 word is zero-extended; paired banks carry the even tf on top.
    assign w_pack      = (r_slot == '0) ? {{P_WIDTH{1'b0}}, tf_in} : {r_hold, tf_in};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)      w_state_nxt = LOAD;
            LOAD:    if (w_run_last) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot    <= '0;
            r_row     <= '0;
            r_hold    <= '0;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= '0;
            r_done  <= w_run_last;
            if (w_accept) begin
                if (w_slot_last) begin
                    r_slot <= '0;
                    // Counters return to zero at run end so the next run starts clean.
                    r_row  <= w_row_last ? '0 : r_row + ADDR_WIDTH'(1);
                end else begin
                    r_slot <= r_slot + SLOT_W'(1);
                end
                if (r_slot[0]) begin
                    r_hold <= tf_in;
                end else begin
                    r_wr_en   <= w_bank_sel;
                    r_wr_addr <= r_row;
                    r_wr_data <= w_pack;
                end
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign done    = r_done;

endmodule

// File: tb/tb_horizontal_tf_packer.sv
module tb_horizontal_tf_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=1 instance
    logic         st1 = 1'b0, vl1 = 1'b0;
    logic [63:0]  tf1 = '0;
    logic         rdy1, busy1, done1;
    logic [0:0]   addr1;
    logic [127:0] data1;
    logic [7:0]   en1;

    // DEPTH=4 instance
    logic         st4 = 1'b0, vl4 = 1'b0;
    logic [63:0]  tf4 = '0;
    logic         rdy4, busy4, done4;
    logic [1:0]   addr4;
    logic [127:0] data4;
    logic [7:0]   en4;

    horizontal_tf_packer #(.P_WIDTH(64), .SD_WIDTH(128), .ADDR_WIDTH(1), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .tf_in(tf1), .tf_in_valid(vl1),
        .tf_in_ready(rdy1), .wr_addr(addr1), .wr_data(data1), .wr_en(en1),
        .busy(busy1), .done(done1)
    );

    horizontal_tf_packer #(.P_WIDTH(64), .SD_WIDTH(128), .ADDR_WIDTH(2), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(st4), .tf_in(tf4), .tf_in_valid(vl4),
        .tf_in_ready(rdy4), .wr_addr(addr4), .wr_data(data4), .wr_en(en4),
        .busy(busy4), .done(done4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: expected bank writes derived from the layout rule
    typedef struct {
        int           bank;
        int           addr;
        logic [127:0] data;
        bit           last;
    } wr_t;

    wr_t          exp_q[$];
    logic [63:0]  sent[60];
    logic [127:0] mem[8][4];
    int           wr_seen  = 0;
    int           done_cnt = 0;
    bit           mon_en   = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done4) done_cnt++;
            if (en4 != 8'h00) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 128'(en4), 128'(0));
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_en", 128'(en4), 128'(8'(1) << e.bank));
                    chk("wr_addr", 128'(addr4), 128'(e.addr));
                    chk("wr_data", data4, e.data);
                    chk("done_align", 128'(done4), 128'(e.last));
                    mem[e.bank][e.addr] = data4;
                end
            end else begin
                chk("done_without_write", 128'(done4), 128'(0));
            end
        end
    end

    // One run on the DEPTH=4 instance: 60 random beats with random bubbles,
    // a forced bubble after every odd-slot beat.
    task automatic do_run(input int start_at, input int abort_after, input bit chain,
                          input bit prestarted, output int acc);
        int  cyc;
        bit  force_bub;
        bit  s_sent;
        int  nexp;
        for (int i = 0; i < 60; i++) sent[i] = {$urandom, $urandom};
        exp_q.delete();
        for (int r = 0; r < 4; r++) begin
            wr_t w;
            w.bank = 0; w.addr = r; w.data = {64'h0, sent[15*r]}; w.last = 1'b0;
            exp_q.push_back(w);
            for (int k = 1; k < 8; k++) begin
                w.bank = k; w.addr = r;
                w.data = {sent[15*r + 2*k - 1], sent[15*r + 2*k]};
                w.last = (r == 3) && (k == 7);
                exp_q.push_back(w);
            end
        end
        for (int b = 0; b < 8; b++)
            for (int r = 0; r < 4; r++) mem[b][r] = 'x;
        wr_seen = 0;
        if (!prestarted) begin
            @(negedge clk); st4 = 1'b1;
            @(negedge clk); st4 = 1'b0;
        end else begin
            @(negedge clk); st4 = 1'b0;
        end
        chk("ready_after_start", 128'(rdy4), 128'(1));
        acc = 0; cyc = 0; force_bub = 1'b0; s_sent = 1'b0;
        while (acc < 60 && cyc < 3000) begin
            if (abort_after >= 0 && acc == abort_after) break;
            tf4 = sent[acc];
            vl4 = force_bub ? 1'b0 : ($urandom_range(0, 99) >= 40);
            if (start_at >= 0 && acc == start_at && !s_sent) begin
                st4 = 1'b1; s_sent = 1'b1;
            end
            if (vl4 && rdy4) begin
                force_bub = ((acc % 15) % 2) == 1;
                acc++;
            end else begin
                force_bub = 1'b0;
            end
            @(negedge clk);
            st4 = 1'b0;
            cyc++;
        end
        vl4 = 1'b0;
        if (cyc >= 3000) begin
            chk("run_timeout", 128'(acc), 128'(60));
        end else if (abort_after >= 0) begin
            rst = 1'b1; vl4 = 1'b1; st4 = 1'b1;
            @(posedge clk); #1;
            chk("abort_wr_en", 128'(en4), 128'(0));
            chk("abort_wr_addr", 128'(addr4), 128'(0));
            chk("abort_wr_data", data4, 128'(0));
            chk("abort_busy", 128'(busy4), 128'(0));
            chk("abort_done", 128'(done4), 128'(0));
            chk("abort_ready", 128'(rdy4), 128'(0));
            @(negedge clk);
            rst = 1'b0; vl4 = 1'b0; st4 = 1'b0;
            nexp = 0;
            for (int j = 0; j < abort_after; j++) if (((j % 15) % 2) == 0) nexp++;
            chk("abort_write_count", 128'(wr_seen), 128'(nexp));
            exp_q.delete();
        end else begin
            chk("done_with_last", 128'(done4), 128'(1));
            chk("busy_at_done", 128'(busy4), 128'(0));
            if (chain) st4 = 1'b1;
            #1;
            chk("write_count", 128'(wr_seen), 128'(32));
            // Read back through the unpacking rule and compare with what was sent.
            for (int r = 0; r < 4; r++) begin
                chk("bank0_upper_zero", 128'(mem[0][r][127:64]), 128'(0));
                chk("unpack_tf1", 128'(mem[0][r][63:0]), 128'(sent[15*r]));
                for (int k = 1; k < 8; k++) begin
                    chk("unpack_tf_even", 128'(mem[k][r][127:64]), 128'(sent[15*r + 2*k - 1]));
                    chk("unpack_tf_odd", 128'(mem[k][r][63:0]), 128'(sent[15*r + 2*k]));
                end
            end
        end
    endtask

    typedef struct {
        logic [63:0]  tf;
        logic [7:0]   en;
        logic [127:0] data;
        logic         done;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int acc;
        int d0;

        tbl[0]  = '{64'h1001, 8'h01, {64'h0,    64'h1001}, 1'b0};
        tbl[1]  = '{64'h1002, 8'h00, {64'h0,    64'h1001}, 1'b0};
        tbl[2]  = '{64'h1003, 8'h02, {64'h1002, 64'h1003}, 1'b0};
        tbl[3]  = '{64'h1004, 8'h00, {64'h1002, 64'h1003}, 1'b0};
        tbl[4]  = '{64'h1005, 8'h04, {64'h1004, 64'h1005}, 1'b0};
        tbl[5]  = '{64'h1006, 8'h00, {64'h1004, 64'h1005}, 1'b0};
        tbl[6]  = '{64'h1007, 8'h08, {64'h1006, 64'h1007}, 1'b0};
        tbl[7]  = '{64'h1008, 8'h00, {64'h1006, 64'h1007}, 1'b0};
        tbl[8]  = '{64'h1009, 8'h10, {64'h1008, 64'h1009}, 1'b0};
        tbl[9]  = '{64'h100A, 8'h00, {64'h1008, 64'h1009}, 1'b0};
        tbl[10] = '{64'h100B, 8'h20, {64'h100A, 64'h100B}, 1'b0};
        tbl[11] = '{64'h100C, 8'h00, {64'h100A, 64'h100B}, 1'b0};
        tbl[12] = '{64'h100D, 8'h40, {64'h100C, 64'h100D}, 1'b0};
        tbl[13] = '{64'h100E, 8'h00, {64'h100C, 64'h100D}, 1'b0};
        tbl[14] = '{64'h100F, 8'h80, {64'h100E, 64'h100F}, 1'b1};

        // Reset with valid and start asserted
        rst = 1'b1; st1 = 1'b1; vl1 = 1'b1; st4 = 1'b1; vl4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 128'(en4), 128'(0));
        chk("rst_done", 128'(done4), 128'(0));
        chk("rst_busy", 128'(busy4), 128'(0));
        chk("rst_ready", 128'(rdy4), 128'(0));
        chk("rst_wr_addr", 128'(addr4), 128'(0));
        chk("rst_wr_data", data4, 128'(0));
        chk("rst_d1_wr_en", 128'(en1), 128'(0));
        chk("rst_d1_busy", 128'(busy1), 128'(0));
        @(negedge clk);
        rst = 1'b0; st1 = 1'b0; vl1 = 1'b0; st4 = 1'b0; vl4 = 1'b0;
        mon_en = 1'b1;

        // Single row on the DEPTH=1 instance, table driven
        @(negedge clk); st1 = 1'b1;
        @(negedge clk); st1 = 1'b0;
        chk("d1_busy", 128'(busy1), 128'(1));
        for (int i = 0; i < 15; i++) begin
            tf1 = tbl[i].tf; vl1 = 1'b1;
            @(posedge clk); #1;
            chk("d1_wr_en", 128'(en1), 128'(tbl[i].en));
            chk("d1_wr_data", data1, tbl[i].data);
            chk("d1_wr_addr", 128'(addr1), 128'(0));
            chk("d1_done", 128'(done1), 128'(tbl[i].done));
            @(negedge clk);
        end
        vl1 = 1'b0;
        chk("d1_busy_after", 128'(busy1), 128'(0));
        @(posedge clk); #1;
        chk("d1_done_single", 128'(done1), 128'(0));
        chk("d1_no_write_after", 128'(en1), 128'(0));

        // Full randomized run with bubbles
        d0 = done_cnt;
        do_run(-1, -1, 1'b0, 1'b0, acc);
        chk("beats_accepted", 128'(acc), 128'(60));
        @(negedge clk);
        chk("done_low_after", 128'(done4), 128'(0));
        chk("busy_low_after", 128'(busy4), 128'(0));
        chk("done_pulses_run1", 128'(done_cnt - d0), 128'(1));

        // Spurious start mid-run
        d0 = done_cnt;
        do_run(7, -1, 1'b0, 1'b0, acc);
        @(negedge clk);
        chk("done_pulses_midstart", 128'(done_cnt - d0), 128'(1));
        chk("idle_after_midstart", 128'(busy4), 128'(0));

        // Reset mid-run, then a clean restart
        d0 = done_cnt;
        do_run(-1, 20, 1'b0, 1'b0, acc);
        chk("no_done_on_abort", 128'(done_cnt - d0), 128'(0));
        do_run(-1, -1, 1'b0, 1'b0, acc);
        @(negedge clk);
        chk("done_pulses_restart", 128'(done_cnt - d0), 128'(1));

        // Back-to-back runs: start in the done cycle
        d0 = done_cnt;
        do_run(-1, -1, 1'b1, 1'b0, acc);
        do_run(-1, -1, 1'b0, 1'b1, acc);
        @(negedge clk);
        chk("done_pulses_b2b", 128'(done_cnt - d0), 128'(2));
        chk("idle_after_b2b", 128'(busy4), 128'(0));

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
